// File: rtl/wb_periph_pkg.sv
// wb_periph_pkg: register map, field positions and encodings shared by the Wishbone peripheral controller.
package wb_periph_pkg;

    typedef enum logic [1:0] {
        SYS_UART  = 2'b00,
        SYS_SPI   = 2'b01,
        SYS_HACK  = 2'b10,
        SYS_RISCV = 2'b11
    } sys_sel_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACK,
        ST_HOLD
    } bus_state_t;

    // word offsets, compared against adr[7:2]
    localparam logic [5:0] OFF_CTRL     = 6'h00;
    localparam logic [5:0] OFF_CMD      = 6'h01;
    localparam logic [5:0] OFF_DATA     = 6'h02;
    localparam logic [5:0] OFF_STATUS   = 6'h03;
    localparam logic [5:0] OFF_IRQ_EN   = 6'h04;
    localparam logic [5:0] OFF_IRQ_STAT = 6'h05;

    localparam int CTRL_SYS_SEL   = 0;
    localparam int CTRL_PARITYEN  = 2;
    localparam int CTRL_PARITYODD = 3;
    localparam int CTRL_CLK_RATIO = 8;

    localparam int CMD_START_TX  = 0;
    localparam int CMD_START_RX  = 1;
    localparam int CMD_START_SPI = 2;

endpackage

// File: rtl/wb_periph_if.sv
// wb_periph_if: Wishbone classic bus between a master and the peripheral controller.
interface wb_periph_if;
    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/wb_periph_irq.sv
// wb_periph_irq: status rising-edge capture into write-1-to-clear IRQ_STAT, IRQ_EN mask and registered irq.
module wb_periph_irq #(
    parameter int STATUS_W = 8
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic [STATUS_W-1:0] status_i,
    input  logic                en_we,
    input  logic                clr_we,
    input  logic [STATUS_W-1:0] wdata,
    output logic [STATUS_W-1:0] irq_en,
    output logic [STATUS_W-1:0] irq_stat,
    output logic                irq_o
);
    logic [STATUS_W-1:0] prev;
    logic [STATUS_W-1:0] rise;
    logic                primed;

    // the first clock after reset only loads prev, so levels already high are not edges
    assign rise = status_i & ~prev & {STATUS_W{primed}};

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            prev     <= '0;
            primed   <= 1'b0;
            irq_en   <= '0;
            irq_stat <= '0;
            irq_o    <= 1'b0;
        end else begin
            prev     <= status_i;
            primed   <= 1'b1;
            irq_en   <= en_we ? wdata : irq_en;
            irq_stat <= (irq_stat & ~(clr_we ? wdata : '0)) | rise;
            irq_o    <= |(irq_stat & irq_en);
        end
    end
endmodule

// File: rtl/wb_periph_ctrl.sv
// wb_periph_ctrl: Wishbone register block for UART/SPI control, FIFO access and status.
// Define WB_PERIPH_IRQ_EN to build IRQ_EN/IRQ_STAT and the interrupt output.
module wb_periph_ctrl
    import wb_periph_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          STATUS_W  = 8
) (
    input  logic                clock,
    input  logic                reset_n,
    wb_periph_if.slave          wbs,
    output logic [1:0]          sys_sel_o,
    output logic [7:0]          clk_ratio_o,
    output logic                parityen_o,
    output logic                parityodd_o,
    output logic                start_tx_o,
    output logic                start_rx_o,
    output logic                start_spi_o,
    output logic                fifo_wren_o,
    output logic                fifo_rden_o,
    output logic [31:0]         wdata_o,
    input  logic [31:0]         rdata_i,
    input  logic [STATUS_W-1:0] status_i,
    output logic                irq_o
);
    bus_state_t  state, state_nxt;
    logic        strobe, req, hit, acc_wr, acc_rd;
    logic [5:0]  off;
    logic [31:0] ctrl_word, rd_data;
    logic        unused_bits;

    assign strobe      = wbs.wbs_cyc_i & wbs.wbs_stb_i;
    assign req         = strobe && wbs.wbs_adr_i[31:8] == BASE_ADDR[31:8];
    assign off         = wbs.wbs_adr_i[7:2];
    assign acc_wr      = hit & wbs.wbs_we_i;
    assign acc_rd      = hit & ~wbs.wbs_we_i;
    assign unused_bits = ^{wbs.wbs_adr_i[1:0], wbs.wbs_sel_i[3:2]};

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else state <= state_nxt;
    end

    // a served strobe must be released before another access is accepted
    always_comb begin
        state_nxt = (state == ST_IDLE) ? (req ? ST_ACK : ST_IDLE) : (strobe ? ST_HOLD : ST_IDLE);
    end

    always_comb begin
        hit           = req && state == ST_IDLE;
        wbs.wbs_ack_o = state == ST_ACK;
    end

    always_comb begin
        ctrl_word                           = '0;
        ctrl_word[CTRL_SYS_SEL +: 2]        = sys_sel_o;
        ctrl_word[CTRL_PARITYEN]            = parityen_o;
        ctrl_word[CTRL_PARITYODD]           = parityodd_o;
        ctrl_word[CTRL_CLK_RATIO +: 8]      = clk_ratio_o;
    end

`ifdef WB_PERIPH_IRQ_EN
    logic [STATUS_W-1:0] irq_en, irq_stat;

    wb_periph_irq #(.STATUS_W(STATUS_W)) u_irq (
        .clock    (clock),
        .reset_n  (reset_n),
        .status_i (status_i),
        .en_we    (acc_wr && off == OFF_IRQ_EN),
        .clr_we   (acc_wr && off == OFF_IRQ_STAT),
        .wdata    (wbs.wbs_dat_i[STATUS_W-1:0]),
        .irq_en   (irq_en),
        .irq_stat (irq_stat),
        .irq_o    (irq_o)
    );

    always_comb begin
        rd_data = (off == OFF_CTRL)     ? ctrl_word :
                  (off == OFF_DATA)     ? rdata_i :
                  (off == OFF_STATUS)   ? 32'(status_i) :
                  (off == OFF_IRQ_EN)   ? 32'(irq_en) :
                  (off == OFF_IRQ_STAT) ? 32'(irq_stat) : '0;
    end
`else
    assign irq_o = 1'b0;

    always_comb begin
        rd_data = (off == OFF_CTRL)   ? ctrl_word :
                  (off == OFF_DATA)   ? rdata_i :
                  (off == OFF_STATUS) ? 32'(status_i) : '0;
    end
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wbs.wbs_dat_o <= '0;
            sys_sel_o     <= SYS_UART;
            clk_ratio_o   <= '0;
            parityen_o    <= 1'b0;
            parityodd_o   <= 1'b0;
            start_tx_o    <= 1'b0;
            start_rx_o    <= 1'b0;
            start_spi_o   <= 1'b0;
            fifo_wren_o   <= 1'b0;
            fifo_rden_o   <= 1'b0;
            wdata_o       <= '0;
        end else begin
            wbs.wbs_dat_o <= hit ? (wbs.wbs_we_i ? '0 : rd_data) : wbs.wbs_dat_o;
            start_tx_o    <= acc_wr && off == OFF_CMD && wbs.wbs_dat_i[CMD_START_TX];
            start_rx_o    <= acc_wr && off == OFF_CMD && wbs.wbs_dat_i[CMD_START_RX];
            start_spi_o   <= acc_wr && off == OFF_CMD && wbs.wbs_dat_i[CMD_START_SPI];
            fifo_wren_o   <= acc_wr && off == OFF_DATA;
            fifo_rden_o   <= acc_rd && off == OFF_DATA;
            wdata_o       <= (acc_wr && off == OFF_DATA) ? wbs.wbs_dat_i : wdata_o;
            if (acc_wr && off == OFF_CTRL && wbs.wbs_sel_i[0]) begin
                sys_sel_o   <= wbs.wbs_dat_i[CTRL_SYS_SEL +: 2];
                parityen_o  <= wbs.wbs_dat_i[CTRL_PARITYEN];
                parityodd_o <= wbs.wbs_dat_i[CTRL_PARITYODD];
            end
            if (acc_wr && off == OFF_CTRL && wbs.wbs_sel_i[1]) clk_ratio_o <= wbs.wbs_dat_i[CTRL_CLK_RATIO +: 8];
        end
    end
endmodule

// File: tb/tb_wb_periph_ctrl.sv
// tb_wb_periph_ctrl: randomized Wishbone traffic against a register-map model, plus directed scenarios.
module tb_wb_periph_ctrl;
    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] rdata_i = '0;
    logic [7:0]  status_i = '0;
    logic [1:0]  sys_sel_o;
    logic [7:0]  clk_ratio_o;
    logic        parityen_o, parityodd_o, start_tx_o, start_rx_o, start_spi_o;
    logic        fifo_wren_o, fifo_rden_o, irq_o;
    logic [31:0] wdata_o;
    int          n_cmp = 0, n_fail = 0;
    int          c_tx = 0, c_rx = 0, c_spi = 0, c_rden = 0, c_ack = 0;
    logic        rnd = 1'b0;

    wb_periph_if wb();

    wb_periph_ctrl dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .wbs         (wb),
        .sys_sel_o   (sys_sel_o),
        .clk_ratio_o (clk_ratio_o),
        .parityen_o  (parityen_o),
        .parityodd_o (parityodd_o),
        .start_tx_o  (start_tx_o),
        .start_rx_o  (start_rx_o),
        .start_spi_o (start_spi_o),
        .fifo_wren_o (fifo_wren_o),
        .fifo_rden_o (fifo_rden_o),
        .wdata_o     (wdata_o),
        .rdata_i     (rdata_i),
        .status_i    (status_i),
        .irq_o       (irq_o)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model: register map plus bus acceptance rules
    logic        m_ack = 0, m_held = 0, m_rd = 0;
    logic [31:0] m_ctrl = '0, m_dat = '0, m_wdata = '0;
    logic        m_tx = 0, m_rx = 0, m_spi = 0, m_wren = 0, m_rden = 0, m_irq = 0, m_primed = 0;
    logic [7:0]  m_en = '0, m_stat = '0, m_prev = '0;
    logic [5:0]  m_off;
    logic        m_acc, m_wr;
    logic [31:0] m_mask;

    assign m_off  = wb.wbs_adr_i[7:2];
    assign m_acc  = wb.wbs_cyc_i && wb.wbs_stb_i && wb.wbs_adr_i[31:8] == 24'h30_0000 && !m_ack && !m_held;
    assign m_wr   = m_acc && wb.wbs_we_i;
    assign m_mask = {16'h0, {8{wb.wbs_sel_i[1]}}, {8{wb.wbs_sel_i[0]}}} & 32'h0000_FF0F;

    function automatic logic [31:0] mread(input logic [5:0] o);
        case (o)
            6'd0: return m_ctrl;
            6'd2: return rdata_i;
            6'd3: return {24'h0, status_i};
`ifdef WB_PERIPH_IRQ_EN
            6'd4: return {24'h0, m_en};
            6'd5: return {24'h0, m_stat};
`endif
            default: return 32'h0;
        endcase
    endfunction

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_ack <= 0; m_held <= 0; m_rd <= 0; m_ctrl <= '0; m_dat <= '0; m_wdata <= '0;
            m_tx <= 0; m_rx <= 0; m_spi <= 0; m_wren <= 0; m_rden <= 0;
            m_irq <= 0; m_primed <= 0; m_en <= '0; m_stat <= '0; m_prev <= '0;
        end else begin
            m_ack  <= m_acc;
            m_held <= (m_ack || m_held) && wb.wbs_cyc_i && wb.wbs_stb_i;
            m_rd   <= m_acc && !wb.wbs_we_i;
            if (m_acc && !wb.wbs_we_i) m_dat <= mread(m_off);
            if (m_wr && m_off == 6'd0) m_ctrl <= (m_ctrl & ~m_mask) | (wb.wbs_dat_i & m_mask);
            if (m_wr && m_off == 6'd2) m_wdata <= wb.wbs_dat_i;
            m_tx   <= m_wr && m_off == 6'd1 && wb.wbs_dat_i[0];
            m_rx   <= m_wr && m_off == 6'd1 && wb.wbs_dat_i[1];
            m_spi  <= m_wr && m_off == 6'd1 && wb.wbs_dat_i[2];
            m_wren <= m_wr && m_off == 6'd2;
            m_rden <= m_acc && !wb.wbs_we_i && m_off == 6'd2;
`ifdef WB_PERIPH_IRQ_EN
            m_prev   <= status_i;
            m_primed <= 1;
            m_irq    <= |(m_stat & m_en);
            if (m_wr && m_off == 6'd4) m_en <= wb.wbs_dat_i[7:0];
            m_stat <= (m_stat & ~((m_wr && m_off == 6'd5) ? wb.wbs_dat_i[7:0] : 8'h0))
                    | (status_i & ~m_prev & {8{m_primed}});
`endif
        end
    end

    // ---------------- per-cycle compare
    logic [18:0] act_o, exp_o;
    assign act_o = {wb.wbs_ack_o, sys_sel_o, parityen_o, parityodd_o, clk_ratio_o,
                    start_tx_o, start_rx_o, start_spi_o, fifo_wren_o, fifo_rden_o, irq_o};
    assign exp_o = {m_ack, m_ctrl[1:0], m_ctrl[2], m_ctrl[3], m_ctrl[15:8],
                    m_tx, m_rx, m_spi, m_wren, m_rden, m_irq};

    always @(negedge clock) begin
        chk("outputs", act_o, exp_o);
        chk("wdata", wdata_o, m_wdata);
        if (m_ack && m_rd) chk("rdata", wb.wbs_dat_o, m_dat);
        c_tx   <= c_tx + int'(start_tx_o);
        c_rx   <= c_rx + int'(start_rx_o);
        c_spi  <= c_spi + int'(start_spi_o);
        c_rden <= c_rden + int'(fifo_rden_o);
        c_ack  <= c_ack + int'(wb.wbs_ack_o);
    end

    // ---------------- bus driver
    task automatic tick();
        @(posedge clock);
        #2;
        if (rnd) begin
            status_i = 8'($urandom);
            rdata_i  = $urandom;
        end
    endtask

    task automatic bus(input logic we, input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                       input int extra, input int budget, output logic got, output logic [31:0] rd, output int lat);
        got = 0; rd = '0; lat = 0;
        wb.wbs_cyc_i = 1; wb.wbs_stb_i = 1; wb.wbs_we_i = we;
        wb.wbs_adr_i = adr; wb.wbs_dat_i = dat; wb.wbs_sel_i = sel;
        for (int i = 0; i < budget && !got; i++) begin
            tick();
            lat = i + 1;
            if (wb.wbs_ack_o) begin
                got = 1;
                rd  = wb.wbs_dat_o;
            end
        end
        repeat (extra) tick();
        wb.wbs_cyc_i = 0; wb.wbs_stb_i = 0;
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: summary not reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic        got;
        logic [31:0] rd;
        int          lat, t0, t1, t2;
        wb.wbs_cyc_i = 0; wb.wbs_stb_i = 0; wb.wbs_we_i = 0;
        wb.wbs_sel_i = '0; wb.wbs_adr_i = '0; wb.wbs_dat_i = '0;
        repeat (3) @(posedge clock);
        #2 reset_n = 1;
        chk("reset_state", {act_o, wdata_o, wb.wbs_dat_o}, 83'h0);
        tick();

        bus(1, 32'h3000_0000, 32'h0000_2A06, 4'hF, 0, 8, got, rd, lat);
        chk("ctrl_wr_lat", lat, 1);
        chk("ctrl_fields", {sys_sel_o, parityen_o, parityodd_o, clk_ratio_o}, {2'b10, 1'b1, 1'b0, 8'h2A});
        bus(0, 32'h3000_0000, 32'h0, 4'hF, 0, 8, got, rd, lat);
        chk("ctrl_readback", rd, 32'h0000_2A06);

        t0 = c_tx; t1 = c_rx; t2 = c_spi;
        bus(1, 32'h3000_0004, 32'h5, 4'hF, 2, 8, got, rd, lat);
        chk("cmd_pulses", {32'(c_tx - t0), 32'(c_rx - t1), 32'(c_spi - t2)}, {32'd1, 32'd0, 32'd1});

        rdata_i = 32'hDEAD_BEEF;
        t0 = c_rden;
        bus(0, 32'h3000_0008, 32'h0, 4'hF, 0, 8, got, rd, lat);
        chk("fifo_rd_data", rd, 32'hDEAD_BEEF);
        chk("fifo_rden_cnt", c_rden - t0, 1);

        bus(0, 32'h3000_0100, 32'h0, 4'hF, 0, 10, got, rd, lat);
        chk("oow_noack", got, 0);
        bus(0, 32'h3000_0040, 32'h0, 4'hF, 0, 8, got, rd, lat);
        chk("unmapped_ack_rd", {got, rd}, {1'b1, 32'h0});

`ifdef WB_PERIPH_IRQ_EN
        status_i = 8'h00;
        bus(1, 32'h3000_0010, 32'h1, 4'hF, 0, 8, got, rd, lat);
        bus(1, 32'h3000_0014, 32'hFF, 4'hF, 0, 8, got, rd, lat);
        status_i = 8'h01;
        repeat (3) tick();
        chk("irq_rise", irq_o, 1);
        status_i = 8'h00;
        tick();
        status_i = 8'h01;
        bus(1, 32'h3000_0014, 32'h1, 4'hF, 0, 8, got, rd, lat);
        chk("irq_set_beats_w1c", irq_o, 1);
        bus(1, 32'h3000_0014, 32'h1, 4'hF, 0, 8, got, rd, lat);
        chk("irq_w1c_clears", irq_o, 0);
`else
        bus(0, 32'h3000_0010, 32'h0, 4'hF, 0, 8, got, rd, lat);
        chk("irq_en_absent", rd, 0);
        chk("irq_tied", irq_o, 0);
`endif

        rnd = 1;
        for (int i = 0; i < 250; i++) begin
            logic [5:0]  o;
            logic        win;
            logic [31:0] a;
            o   = ($urandom_range(0, 7) < 6) ? 6'($urandom_range(0, 5)) : 6'($urandom_range(6, 63));
            win = $urandom_range(0, 7) != 0;
            a   = win ? {24'h30_0000, o, 2'($urandom_range(0, 3))}
                      : {24'h30_0001 + 24'($urandom_range(0, 255)), o, 2'b00};
            bus(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)),
                $urandom_range(0, 2), win ? 4 : 3, got, rd, lat);
            chk("rand_hit_ack", got, win);
        end
        rnd = 0;

        bus(1, 32'h3000_0000, 32'h0000_2A06, 4'hF, 0, 8, got, rd, lat);
        @(posedge clock);
        #2;
        wb.wbs_cyc_i = 1; wb.wbs_stb_i = 1; wb.wbs_we_i = 1;
        wb.wbs_adr_i = 32'h3000_0000; wb.wbs_dat_i = 32'h0000_FFFF; wb.wbs_sel_i = 4'hF;
        status_i = 8'hFF;
        #1 reset_n = 0;
        #1;
        chk("rst_async_outs", {act_o, wdata_o, wb.wbs_dat_o}, 83'h0);
        wb.wbs_cyc_i = 0; wb.wbs_stb_i = 0;
        repeat (2) @(posedge clock);
        #2 reset_n = 1;
        t0 = c_ack;
        repeat (5) tick();
        chk("no_ack_after_rst", c_ack - t0, 0);
        bus(0, 32'h3000_0014, 32'h0, 4'hF, 0, 8, got, rd, lat);
        chk("no_spurious_stat", rd, 0);
        chk("ctrl_cleared", {sys_sel_o, parityen_o, clk_ratio_o}, 11'h0);

        repeat (2) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/wb_periph_ctrl.md
WB_PERIPH_CTRL -- requirements
Module: wb_periph_ctrl

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h3000_0000, Wishbone base address; only bits [31:8] are decoded.
REQ-002 SHALL have parameter STATUS_W, default 8, width of the peripheral status vector.
REQ-003 clock  in  1  system clock; the only clock; all logic on its rising edge.
REQ-004 reset_n  in  1  reset; asynchronous assert, active-low.
REQ-005 wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1 each  Wishbone cycle, strobe and write-enable.
REQ-006 wbs_sel_i  in  4  byte lanes; wbs_adr_i  in  32  address; wbs_dat_i  in  32  write data.
REQ-007 wbs_ack_o  out  1  acknowledge; wbs_dat_o  out  32  read data.
REQ-008 sys_sel_o  out  2  subsystem select (00 UART, 01 SPI, 10 HACK, 11 RISC-V).
REQ-009 clk_ratio_o  out  8  baud/SCLK divider; parityen_o, parityodd_o  out  1 each  UART parity controls.
REQ-010 start_tx_o, start_rx_o, start_spi_o, fifo_wren_o, fifo_rden_o  out  1 each  single-cycle command pulses.
REQ-011 wdata_o  out  32  FIFO write data; rdata_i  in  32  FIFO read data.
REQ-012 status_i  in  STATUS_W  busy/full/empty flags; irq_o  out  1  interrupt request.

Function
REQ-013 SHALL decode a hit when wbs_cyc_i & wbs_stb_i and wbs_adr_i[31:8]==BASE_ADDR[31:8]; offset is wbs_adr_i[7:2].
REQ-014 SHALL assert wbs_ack_o for exactly one cycle, in the cycle after a hit, and never on consecutive cycles; a hit with wbs_ack_o high is ignored.
REQ-015 SHALL never ack a non-hit; an unmapped offset inside the window SHALL ack, read 0 and ignore writes.
REQ-016 Offset 0x00 CTRL, R/W: [1:0] sys_sel, [2] parityen, [3] parityodd, [15:8] clk_ratio; writes are byte-lane masked by wbs_sel_i.
REQ-017 Offset 0x04 CMD, write-only: bit0 start_tx, bit1 start_rx, bit2 start_spi; each set bit pulses its output for one cycle, coincident with ack; reads return 0.
REQ-018 Offset 0x08 DATA: write drives wdata_o=wbs_dat_i and pulses fifo_wren_o for one cycle; read returns rdata_i sampled at the hit and pulses fifo_rden_o once.
REQ-019 Offset 0x0C STATUS, read-only: zero-extended status_i registered at the hit.
REQ-020 Offset 0x10 IRQ_EN R/W [STATUS_W-1:0]; offset 0x14 IRQ_STAT: write-1-to-clear.
REQ-021 IRQ_STAT bit n SHALL set on a rising edge of status_i[n] (registered previous value); a set and a W1C on the same bit in the same cycle SHALL leave the bit set.
REQ-022 irq_o SHALL be registered |(IRQ_STAT & IRQ_EN).
REQ-023 Command pulses SHALL NOT repeat if wbs_stb_i is held after ack.

Reset
REQ-024 reset_n low SHALL asynchronously clear all registers: wbs_ack_o=0, wbs_dat_o=0, sys_sel_o=00, clk_ratio_o=0, parity outputs 0, all pulses 0, wdata_o=0, IRQ_EN=0, IRQ_STAT=0, irq_o=0.
REQ-025 Reset during a pending access SHALL drop the access with no ack after release; the edge-detect register SHALL load status_i on the first clock after release, with no spurious IRQ_STAT set.

Configuration
REQ-026 Macro WB_PERIPH_IRQ_EN defined: REQ-020 to REQ-022 implemented.
REQ-027 Macro WB_PERIPH_IRQ_EN undefined: offsets 0x10 and 0x14 read 0, writes are ignored, irq_o is tied to 0, and the edge-detect logic is absent.

Structure
REQ-028 A shared package wb_periph_pkg SHALL hold the register offset constants, the CTRL/CMD bit positions and the sys_sel encodings.
REQ-029 A single sub-module wb_periph_irq SHALL contain the edge detect, IRQ_STAT, IRQ_EN and irq_o logic, instantiated only under WB_PERIPH_IRQ_EN.

Verification
REQ-030 Write 0x0000_2A06 to 0x3000_0000 with sel=4'hF, then read it back -> ack after 1 cycle; sys_sel_o=10, parityen_o=1, clk_ratio_o=0x2A; read returns 0x0000_2A06.
REQ-031 Write 0x5 to 0x3000_0004 with stb held 3 cycles -> start_tx_o and start_spi_o each high for exactly 1 cycle; start_rx_o stays 0.
REQ-032 Read 0x3000_0008 with rdata_i=0xDEAD_BEEF -> wbs_dat_o=0xDEAD_BEEF; one fifo_rden_o pulse.
REQ-033 Access 0x3000_0100 -> no ack for 10 cycles; access 0x3000_0040 -> ack, read 0.
REQ-034 IRQ_EN=0x01; status_i[0] goes 0->1 -> irq_o=1; a W1C of 0x01 in the same cycle as a new rising edge leaves irq_o=1.
REQ-035 Assert reset_n low mid-write to CTRL -> all outputs 0 immediately; no ack after release.
